// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 4-bit enable/clear counter: drives en/nclr from start/stop/clear commands.
// Optional roll-over counter output `wraps` is built when COUNTER_SEQ_WRAP_CNT_EN is defined.
module counter_seq_ctrl #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_req,
  input  logic [LEN_W-1:0] run_len,
  input  logic [CNT_W-1:0] countv,
  output logic             cnt_en,
  output logic             cnt_nclr,
  output logic             busy,
  output logic             done,
`ifdef COUNTER_SEQ_WRAP_CNT_EN
  output logic [7:0]       wraps,
`endif
  output logic [LEN_W-1:0] elapsed
);

  // state | meaning
  // IDLE  | counter released, waiting for start or clear
  // CLEAR | cnt_nclr held low for CLR_CYC cycles
  // RUN   | cnt_en high, elapsed counting up
  // PAUSE | run suspended, elapsed held
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int unsigned CLR_W = 4;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [LEN_W-1:0]   elapsed_nxt;
  logic               pending, pending_nxt;
  logic [CLR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic               clr_entry;

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state    <= S_IDLE;
      len_q    <= '0;
      elapsed  <= '0;
      pending  <= 1'b0;
      clr_cnt  <= '0;
      cnt_en   <= 1'b0;
      cnt_nclr <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      elapsed  <= elapsed_nxt;
      pending  <= pending_nxt;
      clr_cnt  <= clr_cnt_nxt;
      cnt_en   <= (state_nxt == S_RUN);
      cnt_nclr <= (state_nxt != S_CLEAR);
      busy     <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
      done     <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    elapsed_nxt = elapsed;
    pending_nxt = pending;
    clr_cnt_nxt = clr_cnt;
    clr_entry   = 1'b0;

    case (state)
      S_IDLE: begin
        if (clr_req) begin
          pending_nxt = 1'b0;
          clr_entry   = 1'b1;
        end else if (start) begin
          len_nxt     = run_len;
          elapsed_nxt = '0;
          pending_nxt = 1'b1;
          clr_entry   = 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_req) begin
          pending_nxt = 1'b0;
          clr_entry   = 1'b1;
        end else if (clr_cnt == '0) begin
          pending_nxt = 1'b0;
          if (!pending)           state_nxt = S_IDLE;
          else if (len_q == '0)   state_nxt = S_DONE;
          else                    state_nxt = S_RUN;
        end else begin
          clr_cnt_nxt = clr_cnt - CLR_W'(1);
        end
      end
      S_RUN: begin
        // the enable cycle being issued now is counted even if it is interrupted
        elapsed_nxt = elapsed + LEN_W'(1);
        if (clr_req) begin
          pending_nxt = 1'b0;
          clr_entry   = 1'b1;
        end else if (stop) begin
          state_nxt = S_PAUSE;
        end else if (elapsed == len_q - LEN_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (clr_req) begin
          pending_nxt = 1'b0;
          clr_entry   = 1'b1;
        end else if (!stop && start) begin
          // a stop on the final enable cycle leaves nothing to resume
          state_nxt = (elapsed == len_q) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (clr_entry) begin
      state_nxt   = S_CLEAR;
      clr_cnt_nxt = CLR_W'(CLR_CYC - 1);
    end
  end

`ifdef COUNTER_SEQ_WRAP_CNT_EN
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      wraps <= '0;
    end else if (clr_entry) begin
      wraps <= '0;
    end else if (cnt_en && (&countv) && (wraps != 8'hFF)) begin
      wraps <= wraps + 8'd1;
    end
  end
`else
  logic unused_countv;
  assign unused_countv = ^countv;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed scenarios plus random commands against a phase-based model.
// Covers the wraps output when COUNTER_SEQ_WRAP_CNT_EN is defined.
module tb_counter_seq_ctrl;
  localparam int CNT_W = 4;
  localparam int LEN_W = 8;
  localparam int CLR_CYC = 2;

  logic clk = 1'b0;
  logic nclr = 1'b0;
  logic start = 1'b0, stop = 1'b0, clr_req = 1'b0;
  logic [LEN_W-1:0] run_len = '0;
  logic [CNT_W-1:0] cv;
  logic cnt_en, cnt_nclr, busy, done;
  logic [LEN_W-1:0] elapsed;
`ifdef COUNTER_SEQ_WRAP_CNT_EN
  logic [7:0] wraps;
`endif

  counter_seq_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .nclr(nclr), .start(start), .stop(stop), .clr_req(clr_req),
    .run_len(run_len), .countv(cv), .cnt_en(cnt_en), .cnt_nclr(cnt_nclr),
    .busy(busy), .done(done),
`ifdef COUNTER_SEQ_WRAP_CNT_EN
    .wraps(wraps),
`endif
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // the 4-bit counter being sequenced
  always @(posedge clk or negedge nclr) begin
    if (!nclr)          cv <= '0;
    else if (!cnt_nclr) cv <= '0;
    else if (cnt_en)    cv <= cv + 4'd1;
  end

  // model: clear-cycles remaining, run active/paused flags, remaining work via elapsed vs len
  int m_clr_left, m_len, m_elapsed, m_wraps;
  bit m_active, m_paused, m_pending, m_done;
  bit c_clear, c_run, c_pause, c_done, c_idle;

  always @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      m_clr_left = 0; m_len = 0; m_elapsed = 0; m_wraps = 0;
      m_active = 0; m_paused = 0; m_pending = 0; m_done = 0;
    end else begin
      c_clear = (m_clr_left > 0);
      c_done  = m_done;
      c_run   = m_active && !m_paused && !c_clear;
      c_pause = m_active && m_paused && !c_clear;
      c_idle  = !c_clear && !m_active && !c_done;
      m_done  = 0;
      if (c_run && cv == 4'hF && m_wraps < 255) m_wraps++;
      if (c_done) begin
        m_active = 0;
      end else if (c_idle) begin
        if (clr_req) begin
          m_pending = 0; m_clr_left = CLR_CYC; m_wraps = 0;
        end else if (start) begin
          m_len = int'(run_len); m_elapsed = 0; m_pending = 1;
          m_clr_left = CLR_CYC; m_wraps = 0;
        end
      end else if (c_clear) begin
        if (clr_req) begin
          m_pending = 0; m_clr_left = CLR_CYC; m_wraps = 0;
        end else begin
          m_clr_left--;
          if (m_clr_left == 0 && m_pending) begin
            m_pending = 0;
            if (m_len == 0) m_done = 1;
            else begin m_active = 1; m_paused = 0; end
          end
        end
      end else if (c_run) begin
        m_elapsed++;
        if (clr_req) begin
          m_active = 0; m_pending = 0; m_clr_left = CLR_CYC; m_wraps = 0;
        end else if (stop) begin
          m_paused = 1;
        end else if (m_elapsed == m_len) begin
          m_active = 0; m_done = 1;
        end
      end else if (c_pause) begin
        if (clr_req) begin
          m_active = 0; m_pending = 0; m_clr_left = CLR_CYC; m_wraps = 0;
        end else if (!stop && start) begin
          if (m_elapsed == m_len) begin m_active = 0; m_done = 1; end
          else m_paused = 0;
        end
      end
    end
  end

  int en_total = 0;
  int done_total = 0;

  always @(negedge clk) begin
    check("cnt_en",   int'(cnt_en),   int'(m_active && !m_paused && m_clr_left == 0));
    check("cnt_nclr", int'(cnt_nclr), int'(m_clr_left == 0));
    check("busy",     int'(busy),     int'(m_clr_left > 0 || m_active));
    check("done",     int'(done),     int'(m_done));
    check("elapsed",  int'(elapsed),  m_elapsed);
`ifdef COUNTER_SEQ_WRAP_CNT_EN
    check("wraps",    int'(wraps),    m_wraps);
`endif
    if (cnt_en) en_total++;
    if (done)   done_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    run_len = LEN_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin tick(); k++; end
    check("wait_done", int'(done), 1);
  endtask

  task automatic wait_run_elapsed(input int e, input int limit);
    int k = 0;
    while (!(cnt_en && int'(elapsed) == e) && k < limit) begin tick(); k++; end
    check("wait_run_elapsed", int'(elapsed), e);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((busy || done) && k < limit) begin tick(); k++; end
    check("wait_idle", int'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;
    repeat (5) @(posedge clk);
    #1 nclr = 1'b1;
    tick();
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_cnt_nclr", int'(cnt_nclr), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_elapsed", int'(elapsed), 0);

    // basic run of 20
    e0 = en_total; d0 = done_total;
    pulse_start(20);
    check("basic_clr1", int'(cnt_nclr), 0);
    tick();
    check("basic_clr2", int'(cnt_nclr), 0);
    tick();
    check("basic_first_en", int'(cnt_en), 1);
    wait_done(100);
    tick();
    check("basic_en_cycles", en_total - e0, 20);
    check("basic_done_count", done_total - d0, 1);
    check("basic_countv", int'(cv), 4);
    check("basic_elapsed", int'(elapsed), 20);
`ifdef COUNTER_SEQ_WRAP_CNT_EN
    check("basic_wraps", int'(wraps), 1);
`endif

    // pause and resume, run_len changed at resume must be ignored
    e0 = en_total; d0 = done_total;
    pulse_start(30);
    wait_run_elapsed(9, 100);
    stop = 1'b1; tick(); stop = 1'b0;
    check("pause_en_off", int'(cnt_en), 0);
    check("pause_elapsed", int'(elapsed), 10);
    repeat (15) tick();
    check("pause_hold", int'(elapsed), 10);
    check("pause_busy", int'(busy), 1);
    pulse_start(5);
    wait_done(100);
    tick();
    check("resume_en_cycles", en_total - e0, 30);
    check("resume_countv", int'(cv), 14);
    check("resume_done_count", done_total - d0, 1);
    check("resume_elapsed", int'(elapsed), 30);

    // clear mid-run
    d0 = done_total;
    pulse_start(20);
    wait_run_elapsed(7, 100);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    check("midclr_c1", int'(cnt_nclr), 0);
    tick();
    check("midclr_c2", int'(cnt_nclr), 0);
    tick();
    check("midclr_release", int'(cnt_nclr), 1);
    check("midclr_idle", int'(busy), 0);
    tick();
    check("midclr_countv", int'(cv), 0);
    check("midclr_no_done", done_total - d0, 0);

    // zero length
    e0 = en_total;
    pulse_start(0);
    check("zero_c1", int'(cnt_nclr), 0);
    tick();
    check("zero_c2", int'(cnt_nclr), 0);
    tick();
    check("zero_done", int'(done), 1);
    check("zero_elapsed", int'(elapsed), 0);
    tick();
    check("zero_done_once", int'(done), 0);
    check("zero_no_en", en_total - e0, 0);

    // all three commands in one RUN cycle: clear wins
    pulse_start(20);
    wait_run_elapsed(3, 100);
    start = 1'b1; stop = 1'b1; clr_req = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; clr_req = 1'b0;
    check("prio_clear", int'(cnt_nclr), 0);
    check("prio_no_en", int'(cnt_en), 0);
    check("prio_busy", int'(busy), 1);
    wait_idle(20);

    // asynchronous reset during PAUSE
    pulse_start(20);
    wait_run_elapsed(4, 100);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();
    check("pre_rst_paused", int'(busy), 1);
    #2 nclr = 1'b0;
    #1;
    check("arst_cnt_en", int'(cnt_en), 0);
    check("arst_cnt_nclr", int'(cnt_nclr), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_elapsed", int'(elapsed), 0);
`ifdef COUNTER_SEQ_WRAP_CNT_EN
    check("arst_wraps", int'(wraps), 0);
`endif
    tick(); tick();
    nclr = 1'b1;
    tick();

    // random command traffic
    repeat (3000) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 9) == 0);
      clr_req = ($urandom_range(0, 39) == 0);
      run_len = LEN_W'($urandom_range(0, 40));
      tick();
    end
    start = 1'b0; stop = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_idle(20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
